inta_sequencer: RTL

- Clocked controller that sequences the 8086-mode two-pulse interrupt-acknowledge cycle of the PIC.
- Takes the resolved one-hot interrupt from the priority resolver and raises INT. It then tracks the INTA pulses from the CPU.
- In response it freezes the request path, latches ISR, clears the IRR bit, drives cascade addresses and places the vector on the data bus.
- Sits between the priority resolver, ISR/IRR, cascade logic and the data buffer. It replaces the asynchronous INTA edge handling in the control logic.

---
 rtl/pic_pkg.sv | 25 ++
 rtl/inta_sync.sv | 35 +++
 rtl/inta_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pic_pkg.sv
// Shared PIC types and helpers.
// Used by the acknowledge sequencer and the priority resolver.
package pic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT1,
    ACK1,
    GAP,
    ACK2
  } state_t;

  localparam int VEC_BASE_MSB = 7;
  localparam int VEC_BASE_LSB = 3;

  function automatic logic [2:0] onehot_to_num(input logic [7:0] oh);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (oh[i]) n = 3'(i);
    end
    return n;
  endfunction

endpackage

// File: rtl/inta_sync.sv
// Flop-chain synchroniser with per-bit edge outputs.
// Edges compare the synchronised value with its previous value.
module inta_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] fe,
  output logic [WIDTH-1:0] re
);

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] prev;

  // shift the pin through the chain, keep one extra flop for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= RST_VAL;
      prev <= RST_VAL;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign q  = chain[STAGES-1];
  assign fe = prev & ~q;
  assign re = ~prev & q;

endmodule

// File: rtl/inta_sequencer.sv
// 8086-mode two-pulse INTA sequencer for the PIC.
// Raises INT, tracks both INTA pulses, drives cascade and vector.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int VEC_BITS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INTA_n,
  input  logic [7:0] InterruptID,
  input  logic [7:0] ICW2Cascade,
  input  logic [7:0] ICW3Cascade,
  input  logic       SNGL,
  input  logic       SP_ENCascade,
  input  logic       AEOI,
  input  logic [2:0] CAS_in,
  output logic       INT,
  output logic       freeze,
  output logic       latch_in_service,
  output logic [7:0] clear_interrupt_request,
  output logic [2:0] CAS_out,
  output logic       CAS_oe,
  output logic [7:0] DataBufferOutput,
  output logic       data_oe,
  output logic       end_of_acknowledge_sequence,
  output logic [7:0] aeoi_clear
);

  state_t     state, state_d;
  logic [7:0] id_q, id_d;
  logic       spur_q, spur_d;
  logic [2:0] ir_num, num_d;
  logic       fe, re;
  logic       inta_level_unused;
  logic [2:0] cas_sync;
  logic [5:0] cas_edges_unused;
  logic       master, slave, drive;
  logic       int_d, freeze_d, lis_d, eoa_d;
  logic       cas_oe_d, data_oe_d;
  logic [2:0] cas_out_d;
  logic [7:0] clr_d, dbo_d, aeoi_d;

  inta_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_inta (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (INTA_n),
    .q    (inta_level_unused),
    .fe   (fe),
    .re   (re)
  );

  inta_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (3),
    .RST_VAL(3'd0)
  ) u_cas (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (CAS_in),
    .q    (cas_sync),
    .fe   (cas_edges_unused[2:0]),
    .re   (cas_edges_unused[5:3])
  );

  assign master = !SNGL && SP_ENCascade;
  assign slave  = !SNGL && !SP_ENCascade;
  assign ir_num = onehot_to_num(id_q);
  assign drive  = !(master && ICW3Cascade[ir_num])
               && !(slave && cas_sync != ICW3Cascade[2:0]);

  // next state and next registered outputs
  always_comb begin
    state_d   = state;
    id_d      = id_q;
    spur_d    = spur_q;
    freeze_d  = freeze;
    cas_out_d = CAS_out;
    cas_oe_d  = CAS_oe;
    dbo_d     = DataBufferOutput;
    data_oe_d = data_oe;
    lis_d     = 1'b0;
    clr_d     = '0;
    eoa_d     = 1'b0;
    aeoi_d    = '0;
    num_d     = 3'd0;
    unique case (state)
      IDLE, WAIT1: begin
        if (fe) begin
          state_d  = ACK1;
          freeze_d = 1'b1;
          if (state == WAIT1) begin
            lis_d  = 1'b1;
            clr_d  = id_q;
            spur_d = 1'b0;
          end else begin
            id_d   = 8'h80;
            spur_d = 1'b1;
          end
          num_d = onehot_to_num(id_d);
          if (master && ICW3Cascade[num_d]) begin
            cas_oe_d  = 1'b1;
            cas_out_d = num_d;
          end
        end else if (state == IDLE) begin
          if (InterruptID != 8'h00) begin
            state_d = WAIT1;
            id_d    = InterruptID;
          end
        end else if (InterruptID == 8'h00) begin
          state_d = IDLE;
          id_d    = '0;
        end else begin
          id_d = InterruptID;
        end
      end
      ACK1: begin
        if (re) state_d = GAP;
      end
      GAP: begin
        if (fe) begin
          state_d   = ACK2;
          data_oe_d = drive;
          dbo_d     = drive ?
            {ICW2Cascade[VEC_BASE_MSB -: VEC_BITS], ir_num} : 8'h00;
        end
      end
      ACK2: begin
        if (re) begin
          state_d   = IDLE;
          eoa_d     = 1'b1;
          freeze_d  = 1'b0;
          cas_oe_d  = 1'b0;
          cas_out_d = 3'd0;
          data_oe_d = 1'b0;
          dbo_d     = 8'h00;
          aeoi_d    = (AEOI && !spur_q) ? id_q : 8'h00;
          id_d      = '0;
          spur_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    int_d = (state_d == WAIT1);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                       <= IDLE;
      id_q                        <= '0;
      spur_q                      <= 1'b0;
      INT                         <= 1'b0;
      freeze                      <= 1'b0;
      latch_in_service            <= 1'b0;
      clear_interrupt_request     <= '0;
      CAS_out                     <= '0;
      CAS_oe                      <= 1'b0;
      DataBufferOutput            <= '0;
      data_oe                     <= 1'b0;
      end_of_acknowledge_sequence <= 1'b0;
      aeoi_clear                  <= '0;
    end else begin
      state                       <= state_d;
      id_q                        <= id_d;
      spur_q                      <= spur_d;
      INT                         <= int_d;
      freeze                      <= freeze_d;
      latch_in_service            <= lis_d;
      clear_interrupt_request     <= clr_d;
      CAS_out                     <= cas_out_d;
      CAS_oe                      <= cas_oe_d;
      DataBufferOutput            <= dbo_d;
      data_oe                     <= data_oe_d;
      end_of_acknowledge_sequence <= eoa_d;
      aeoi_clear                  <= aeoi_d;
    end
  end

  // the resolver must present at most one request
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(InterruptID));

endmodule
